// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared state encoding and frame-field constants for the boot loader
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } boot_state_t;

    localparam int LEN_BYTES = 2;
    localparam int CHK_BYTES = 1;
    localparam int LEN_W     = 8 * LEN_BYTES;
    localparam int CHK_W     = 8 * CHK_BYTES;

    // States in which the loader takes bytes from the stream
    function automatic logic state_rx(input boot_state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - big-endian byte-to-word shift register with lane counter
module byte_word_packer #(
    parameter int WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    s_tvalid,
    input  logic [7:0]              s_tdata,
    output logic                    lane_last,
    output logic                    m_tvalid,
    output logic [8*WORD_BYTES-1:0] m_tdata
);

    localparam int W      = 8 * WORD_BYTES;
    localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [LANE_W-1:0] lane;
    logic [W-1:0]      shreg;
    logic [W-1:0]      shreg_next;

    // Earliest byte ends up in the top lane after WORD_BYTES shifts
    assign shreg_next = (shreg << 8) | W'(s_tdata);
    assign lane_last  = (lane == LANE_W'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            lane     <= '0;
            shreg    <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
        end else begin
            m_tvalid <= 1'b0;
            if (clear) begin
                lane  <= '0;
                shreg <= '0;
            end else if (s_tvalid) begin
                shreg <= shreg_next;
                if (lane_last) begin
                    lane     <= '0;
                    m_tvalid <= 1'b1;
                    m_tdata  <= shreg_next;
                end else begin
                    lane <= lane + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - framed byte-stream loader that fills instruction memory and holds the CPU
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W     = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    s_valid,
    input  logic [7:0]              s_data,
    output logic                    s_ready,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    cpu_hold,
    output logic                    done,
    output logic                    error,
    output logic [ADDR_W:0]         words_loaded
);

    boot_state_t       state;
    boot_state_t       state_next;
    logic [7:0]        len_hi;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  len_rx;
    logic [CHK_W-1:0]  xor_acc;
    logic [ADDR_W-1:0] addr_ptr;
    logic              accept;
    logic              restart;
    logic              data_accept;
    logic              lane_last;
    logic              word_done;
    logic              last_word;
    logic              oversize;

    assign accept      = s_valid && s_ready;
    assign restart     = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign data_accept = accept && (state == DATA);
    assign word_done   = data_accept && lane_last;
    assign last_word   = word_done && ((32'(words_loaded) + 32'd1) == 32'(len));
    assign len_rx      = {len_hi, s_data};
    // Image may fill memory exactly, but never more than 2^ADDR_W words
    assign oversize    = 32'(len_rx) > (32'd1 << ADDR_W);

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERROR: if (start) state_next = LEN_HI;
            LEN_HI:            if (accept) state_next = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if (oversize)
                        state_next = ERROR;
                    else if (len_rx == '0)
                        state_next = CHECK;
                    else
                        state_next = DATA;
                end
            end
            DATA:              if (last_word) state_next = CHECK;
            CHECK:             if (accept) state_next = (s_data == xor_acc) ? DONE : ERROR;
            default:           state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            s_ready      <= 1'b0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            len_hi       <= '0;
            len          <= '0;
            xor_acc      <= '0;
            addr_ptr     <= ADDR_W'(BASE_ADDR);
            mem_addr     <= '0;
            words_loaded <= '0;
        end else begin
            state    <= state_next;
            s_ready  <= state_rx(state_next);
            cpu_hold <= (state_next != DONE);
            done     <= (state_next == DONE);
            error    <= (state_next == ERROR);
            if (restart) begin
                xor_acc      <= '0;
                addr_ptr     <= ADDR_W'(BASE_ADDR);
                words_loaded <= '0;
            end
            if (accept && (state == LEN_HI))
                len_hi <= s_data;
            if (accept && (state == LEN_LO))
                len <= len_rx;
            if (data_accept)
                xor_acc <= xor_acc ^ s_data;
            if (word_done) begin
                mem_addr     <= addr_ptr;
                addr_ptr     <= addr_ptr + 1'b1;
                words_loaded <= words_loaded + 1'b1;
            end
        end
    end

    byte_word_packer #(
        .WORD_BYTES (WORD_BYTES)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (restart),
        .s_tvalid  (data_accept),
        .s_tdata   (s_data),
        .lane_last (lane_last),
        .m_tvalid  (mem_we),
        .m_tdata   (mem_wdata)
    );

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - scoreboard bench for the boot loader at base 0 and base 0xFF
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;

    logic        s_ready0, s_ready1;
    logic        we0, we1;
    logic [7:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        hold0, hold1;
    logic        done0, done1;
    logic        err0, err1;
    logic [8:0]  wl0, wl1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [31:0] words [0:7];

    localparam logic [53:0] RESET_VEC = {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 9'h000};

    always #5 clk = ~clk;

    imem_boot_loader #(.WORD_BYTES(4), .ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
        .cpu_hold(hold0), .done(done0), .error(err0), .words_loaded(wl0)
    );

    imem_boot_loader #(.WORD_BYTES(4), .ADDR_W(8), .BASE_ADDR(8'hFF)) dut_wrap (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
        .cpu_hold(hold1), .done(done1), .error(err1), .words_loaded(wl1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (we0) begin
            if (q0.size() == 0) check_eq("we0_unexpected", 64'(we0), 64'd0);
            else check_eq("wr0", {24'h0, addr0, wdata0}, q0.pop_front());
        end
        if (we1) begin
            if (q1.size() == 0) check_eq("we1_unexpected", 64'(we1), 64'd0);
            else check_eq("wr1", {24'h0, addr1, wdata1}, q1.pop_front());
        end
    end

    function automatic logic [53:0] status0();
        return {s_ready0, we0, addr0, wdata0, hold0, done0, err0, wl0};
    endfunction

    function automatic logic [53:0] status1();
        return {s_ready1, we1, addr1, wdata1, hold1, done1, err1, wl1};
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc;
        acc = 1'b0;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        for (int i = 0; i < 20; i++) begin
            acc = s_ready0;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        s_valid = 1'b0;
        if (!acc) check_eq("ready_timeout", 64'(acc), 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // abort_after >= 0 stops after that many payload bytes
    task automatic send_frame(input int n, input bit bad_chk, input bit gaps, input int abort_after);
        logic [7:0] x;
        logic [7:0] b;
        logic [15:0] n16;
        int sent;
        x = 8'h00;
        sent = 0;
        n16 = 16'(n);
        send_byte(n16[15:8], gaps ? int'($urandom_range(0, 3)) : 0);
        send_byte(n16[7:0], gaps ? int'($urandom_range(0, 3)) : 0);
        for (int k = 0; k < n; k++) begin
            for (int j = 3; j >= 0; j--) begin
                if (abort_after >= 0 && sent == abort_after) return;
                b = words[k][8*j +: 8];
                x = x ^ b;
                if (j == 0) begin
                    q0.push_back({24'h0, 8'(k), words[k]});
                    q1.push_back({24'h0, 8'(8'hFF + 8'(k)), words[k]});
                end
                send_byte(b, gaps ? int'($urandom_range(0, 3)) : 0);
                sent++;
            end
        end
        check_eq("hold_before_chk", 64'(hold0), 64'd1);
        send_byte(bad_chk ? ~x : x, gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset0", 64'(status0()), 64'(RESET_VEC));
        check_eq("reset1", 64'(status1()), 64'(RESET_VEC));
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_ready", 64'(s_ready0), 64'd0);

        // Nominal two-word image
        words[0] = 32'hE3A00001;
        words[1] = 32'hE2800005;
        pulse_start();
        check_eq("start_ready", 64'(s_ready0), 64'd1);
        send_frame(2, 1'b0, 1'b0, -1);
        check_eq("done0", 64'({done0, hold0, err0, wl0}), 64'({1'b1, 1'b0, 1'b0, 9'd2}));
        check_eq("done1", 64'({done1, hold1, err1, wl1}), 64'({1'b1, 1'b0, 1'b0, 9'd2}));
        check_eq("q_empty_a", 64'(q0.size() + q1.size()), 64'd0);

        // Bad checksum: writes still happen, then error
        pulse_start();
        check_eq("wl_cleared", 64'(wl0), 64'd0);
        send_frame(2, 1'b1, 1'b0, -1);
        check_eq("err0", 64'({done0, hold0, err0, wl0}), 64'({1'b0, 1'b1, 1'b1, 9'd2}));
        check_eq("err1", 64'({done1, hold1, err1, wl1}), 64'({1'b0, 1'b1, 1'b1, 9'd2}));

        // Random gaps with a longer random image
        for (int i = 0; i < 6; i++) words[i] = $urandom;
        pulse_start();
        send_frame(6, 1'b0, 1'b1, -1);
        check_eq("gap_done", 64'({done0, hold0, err0, wl0}), 64'({1'b1, 1'b0, 1'b0, 9'd6}));
        check_eq("q_empty_b", 64'(q0.size() + q1.size()), 64'd0);

        // Oversize length: 0x0101 > 256
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check_eq("over_err", 64'({err0, s_ready0, hold0, wl0}), 64'({1'b1, 1'b0, 1'b1, 9'd0}));
        s_valid = 1'b1;
        s_data = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_eq("over_noready", 64'(s_ready0), 64'd0);
        end
        s_valid = 1'b0;

        // Reset after five payload bytes
        words[0] = 32'hE3A00001;
        words[1] = 32'hE2800005;
        pulse_start();
        send_frame(2, 1'b0, 1'b0, 5);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midreset0", 64'(status0()), 64'(RESET_VEC));
        check_eq("midreset1", 64'(status1()), 64'(RESET_VEC));
        reset = 1'b0;
        s_valid = 1'b1;
        s_data = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        s_valid = 1'b0;
        check_eq("no_resume", 64'(status0()), 64'(RESET_VEC));
        pulse_start();
        send_frame(2, 1'b0, 1'b0, -1);
        check_eq("reload0", 64'({done0, hold0, err0, wl0}), 64'({1'b1, 1'b0, 1'b0, 9'd2}));
        check_eq("reload1", 64'({done1, hold1, err1, wl1}), 64'({1'b1, 1'b0, 1'b0, 9'd2}));

        repeat (3) @(posedge clk);
        #1;
        check_eq("q_empty_end", 64'(q0.size() + q1.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
